camera_tracker: RTL and testbench

- Upstream producer of the map renderer's camera_y and camera_offset inputs.
- Tracks which level (screen) the player occupies from the player's world Y coordinate.
- Animates a short vertical scroll on every level transition, stepping once per frame tick.
- Exports the world Y of the current level floor (level_base) so physics and sprite stages can convert world Y to screen Y.

---
 rtl/camera_tracker_if.sv | 26 ++
 rtl/camera_tracker.sv | 131 +++++++++++++
 tb/tb_camera_tracker.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/camera_tracker_if.sv
// Bundle between the player/physics side and the camera tracker. The master drives
// player position, frame ticks and load requests; the slave returns the camera state.
interface camera_tracker_if #(
  parameter int PHY_WIDTH    = 16,
  parameter int CAMERA_WIDTH = 6
);
  logic                    frame_tick;
  logic [PHY_WIDTH-1:0]    player_y;
  logic                    load_en;
  logic [CAMERA_WIDTH-1:0] load_level;
  logic [CAMERA_WIDTH-1:0] camera_y;
  logic [CAMERA_WIDTH-1:0] camera_offset;
  logic [PHY_WIDTH-1:0]    level_base;
  logic                    scrolling;
  logic                    level_changed;

  modport master (
    output frame_tick, player_y, load_en, load_level,
    input  camera_y, camera_offset, level_base, scrolling, level_changed
  );

  modport slave (
    input  frame_tick, player_y, load_en, load_level,
    output camera_y, camera_offset, level_base, scrolling, level_changed
  );
endinterface

// File: rtl/camera_tracker.sv
// Follows the player's level from world Y and animates a short vertical scroll on
// each level transition, one step per frame tick. level_base tracks camera_y*LEVEL_HEIGHT.
module camera_tracker #(
  parameter int PHY_WIDTH    = 16,
  parameter int CAMERA_WIDTH = 6,
  parameter int LEVEL_HEIGHT = 480,
  parameter int MAX_LEVEL    = 39,
  parameter int MAX_OFFSET   = 60,
  parameter int SCROLL_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  camera_tracker_if.slave   bus
);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] SCROLL_UP   = 2'd1;
  localparam logic [1:0] SCROLL_DOWN = 2'd2;

  localparam logic [CAMERA_WIDTH-1:0] MAX_LEVEL_C = CAMERA_WIDTH'(MAX_LEVEL);
  localparam logic [CAMERA_WIDTH-1:0] STEP_C      = CAMERA_WIDTH'(SCROLL_STEP);
  localparam logic [CAMERA_WIDTH-1:0] OFF_START_C = CAMERA_WIDTH'(MAX_OFFSET - SCROLL_STEP);
  localparam logic [CAMERA_WIDTH-1:0] ONE_C       = CAMERA_WIDTH'(1);
  localparam logic [PHY_WIDTH-1:0]    HEIGHT_C    = PHY_WIDTH'(LEVEL_HEIGHT);
  localparam logic [CAMERA_WIDTH+1:0] STEP2_W     = (CAMERA_WIDTH+2)'(2 * SCROLL_STEP);
  localparam logic [CAMERA_WIDTH+1:0] MAXOFF_W    = (CAMERA_WIDTH+2)'(MAX_OFFSET);

  logic [1:0]              state_q, state_d;
  logic [CAMERA_WIDTH-1:0] camera_y_q, camera_y_d;
  logic [CAMERA_WIDTH-1:0] camera_offset_q, camera_offset_d;
  logic [PHY_WIDTH-1:0]    level_base_q, level_base_d;
  logic                    scrolling_q, scrolling_d;
  logic                    changed_q, changed_d;
  logic                    level_changed_q, level_changed_d;

  logic [CAMERA_WIDTH-1:0] load_clamped;
  logic [PHY_WIDTH-1:0]    base_load;
  logic                    up_hit;
  logic                    down_hit;
  logic                    up_done;

  always_comb begin
    load_clamped = (bus.load_level > MAX_LEVEL_C) ? MAX_LEVEL_C : bus.load_level;
    base_load    = PHY_WIDTH'(load_clamped) * HEIGHT_C;
    up_hit       = ({1'b0, bus.player_y} >= ({1'b0, level_base_q} + {1'b0, HEIGHT_C}));
    down_hit     = (bus.player_y < level_base_q);
    // Commit once the next step would pass MAX_OFFSET-SCROLL_STEP, so the offset
    // stays bounded even when SCROLL_STEP does not divide MAX_OFFSET.
    up_done      = (({2'b00, camera_offset_q} + STEP2_W) > MAXOFF_W);
  end

  always_comb begin
    state_d         = state_q;
    camera_y_d      = camera_y_q;
    camera_offset_d = camera_offset_q;
    level_base_d    = level_base_q;

    if (bus.load_en) begin
      camera_y_d      = load_clamped;
      level_base_d    = base_load;
      camera_offset_d = '0;
      state_d         = IDLE;
    end else if (bus.frame_tick) begin
      case (state_q)
        IDLE: begin
          if (up_hit && (camera_y_q < MAX_LEVEL_C)) begin
            state_d = SCROLL_UP;
          end else if (down_hit && (camera_y_q != '0)) begin
            camera_y_d      = camera_y_q - ONE_C;
            level_base_d    = level_base_q - HEIGHT_C;
            camera_offset_d = OFF_START_C;
            state_d         = SCROLL_DOWN;
          end
        end
        SCROLL_UP: begin
          if (up_done) begin
            camera_y_d      = camera_y_q + ONE_C;
            level_base_d    = level_base_q + HEIGHT_C;
            camera_offset_d = '0;
            state_d         = IDLE;
          end else begin
            camera_offset_d = camera_offset_q + STEP_C;
          end
        end
        SCROLL_DOWN: begin
          if (camera_offset_q <= STEP_C) begin
            camera_offset_d = '0;
            state_d         = IDLE;
          end else begin
            camera_offset_d = camera_offset_q - STEP_C;
          end
        end
        default: begin
          camera_offset_d = '0;
          state_d         = IDLE;
        end
      endcase
    end

    scrolling_d     = (state_d != IDLE);
    changed_d       = (camera_y_d != camera_y_q);
    level_changed_d = changed_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      camera_y_q      <= '0;
      camera_offset_q <= '0;
      level_base_q    <= '0;
      scrolling_q     <= 1'b0;
      changed_q       <= 1'b0;
      level_changed_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      camera_y_q      <= camera_y_d;
      camera_offset_q <= camera_offset_d;
      level_base_q    <= level_base_d;
      scrolling_q     <= scrolling_d;
      changed_q       <= changed_d;
      level_changed_q <= level_changed_d;
    end
  end

  assign bus.camera_y      = camera_y_q;
  assign bus.camera_offset = camera_offset_q;
  assign bus.level_base    = level_base_q;
  assign bus.scrolling     = scrolling_q;
  assign bus.level_changed = level_changed_q;

endmodule

// File: tb/tb_camera_tracker.sv
// Directed bench for camera_tracker: vector table for the main sequences plus
// hand-written reset, bounded-wait and non-dividing-step cases.
module tb_camera_tracker;

  logic clk;
  logic rst_n;

  camera_tracker_if #(.PHY_WIDTH(16), .CAMERA_WIDTH(6)) bus ();
  camera_tracker_if #(.PHY_WIDTH(16), .CAMERA_WIDTH(6)) bus7 ();

  camera_tracker #(
    .PHY_WIDTH(16), .CAMERA_WIDTH(6), .LEVEL_HEIGHT(480),
    .MAX_LEVEL(39), .MAX_OFFSET(60), .SCROLL_STEP(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  camera_tracker #(
    .PHY_WIDTH(16), .CAMERA_WIDTH(6), .LEVEL_HEIGHT(480),
    .MAX_LEVEL(39), .MAX_OFFSET(60), .SCROLL_STEP(7)
  ) dut7 (
    .clk(clk), .rst_n(rst_n), .bus(bus7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit ft;
    bit le;
    int ll;
    int py;
    int cy;
    int off;
    int base;
    bit scr;
    bit lc;
  } vec_t;

  vec_t vecs[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic void add(input bit ft, input bit le, input int ll, input int py,
                              input int cy, input int off, input int base,
                              input bit scr, input bit lc);
    vec_t v;
    v.ft = ft; v.le = le; v.ll = ll; v.py = py;
    v.cy = cy; v.off = off; v.base = base; v.scr = scr; v.lc = lc;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_main(input string tag, input int cy, input int off, input int base,
                          input int scr, input int lc);
    chk({tag, ".camera_y"},      int'(bus.camera_y),      cy);
    chk({tag, ".camera_offset"}, int'(bus.camera_offset), off);
    chk({tag, ".level_base"},    int'(bus.level_base),    base);
    chk({tag, ".scrolling"},     int'(bus.scrolling),     scr);
    chk({tag, ".level_changed"}, int'(bus.level_changed), lc);
  endtask

  task automatic chk7(input string tag, input int cy, input int off, input int base,
                      input int scr);
    chk({tag, ".camera_y"},      int'(bus7.camera_y),      cy);
    chk({tag, ".camera_offset"}, int'(bus7.camera_offset), off);
    chk({tag, ".level_base"},    int'(bus7.level_base),    base);
    chk({tag, ".scrolling"},     int'(bus7.scrolling),     scr);
  endtask

  // Called at posedge+1; applies inputs across one active edge, samples at next posedge+1.
  task automatic step(input bit ft, input bit le, input int ll);
    bus.frame_tick = ft;
    bus.load_en    = le;
    bus.load_level = 6'(ll);
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b0;
    bus.load_en    = 1'b0;
  endtask

  task automatic step7(input bit ft);
    bus7.frame_tick = ft;
    @(posedge clk);
    #1;
    bus7.frame_tick = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    bus.frame_tick  = 1'b0;
    bus.load_en     = 1'b0;
    bus.load_level  = '0;
    bus.player_y    = 16'd100;
    bus7.frame_tick = 1'b0;
    bus7.load_en    = 1'b0;
    bus7.load_level = '0;
    bus7.player_y   = '0;

    // Idle at level 0 with the player low in the level.
    for (int i = 0; i < 5; i++) add(1, 0, 0, 100, 0, 0, 0, 0, 0);
    // Upward crossing: decision tick, 14 stepping ticks, commit, then the pulse.
    add(1, 0, 0, 500, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 14; k++) add(1, 0, 0, 500, 0, 4 * k, 0, 1, 0);
    add(1, 0, 0, 500, 1, 0, 480, 0, 0);
    add(0, 0, 0, 500, 1, 0, 480, 0, 1);
    add(0, 0, 0, 500, 1, 0, 480, 0, 0);
    add(1, 0, 0, 500, 1, 0, 480, 0, 0);
    // Load level 3, then a three-level fall.
    add(0, 1, 3, 100, 3, 0, 1440, 0, 0);
    add(0, 0, 0, 100, 3, 0, 1440, 0, 1);
    for (int k = 1; k <= 3; k++) begin
      add(1, 0, 0, 100, 3 - k, 56, 1440 - 480 * k, 1, 0);
      for (int j = 1; j <= 13; j++) add(1, 0, 0, 100, 3 - k, 56 - 4 * j, 1440 - 480 * k, 1, j == 1);
      add(1, 0, 0, 100, 3 - k, 0, 1440 - 480 * k, 0, 0);
    end
    add(1, 0, 0, 100, 0, 0, 0, 0, 0);
    // Top level: upward crossing ignored, then an over-range load is clamped.
    add(0, 1, 39, 19500, 39, 0, 18720, 0, 0);
    add(0, 0, 0, 19500, 39, 0, 18720, 0, 1);
    for (int i = 0; i < 20; i++) add(1, 0, 0, 19500, 39, 0, 18720, 0, 0);
    add(0, 1, 50, 19500, 39, 0, 18720, 0, 0);
    add(0, 0, 0, 19500, 39, 0, 18720, 0, 0);
    // Load aborts a scroll in progress at offset 24.
    add(0, 1, 0, 500, 0, 0, 0, 0, 0);
    add(0, 0, 0, 500, 0, 0, 0, 0, 1);
    add(1, 0, 0, 500, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 6; k++) add(1, 0, 0, 500, 0, 4 * k, 0, 1, 0);
    add(1, 1, 7, 500, 7, 0, 3360, 0, 0);
    add(0, 0, 0, 500, 7, 0, 3360, 0, 1);

    #12;
    chk_main("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      bus.player_y = 16'(vecs[i].py);
      step(vecs[i].ft, vecs[i].le, vecs[i].ll);
      chk_main($sformatf("v%0d", i), vecs[i].cy, vecs[i].off, vecs[i].base,
               vecs[i].scr, vecs[i].lc);
    end

    // Reset asserted mid downward scroll clears everything without a clock edge.
    step(1, 0, 0);
    chk_main("down7", 6, 56, 2880, 1, 0);
    step(1, 0, 0);
    chk_main("down7b", 6, 52, 2880, 1, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_main("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_main("post_rst", 0, 0, 0, 0, 0);

    // Bounded wait for the upward commit from level 0.
    bus.player_y = 16'd500;
    n = 0;
    while (bus.camera_y != 6'd1 && n < 40) begin
      step(1, 0, 0);
      n++;
    end
    chk("up_wait.ticks", n, 16);
    chk_main("up_wait", 1, 0, 480, 0, 0);

    // Step of 7 does not divide 60: offsets stay at or below 53 in both directions.
    bus7.player_y = 16'd500;
    step7(1);
    chk7("s7.dec", 0, 0, 0, 1);
    for (int k = 1; k <= 7; k++) begin
      step7(1);
      chk7($sformatf("s7.up%0d", k), 0, 7 * k, 0, 1);
    end
    step7(1);
    chk7("s7.commit", 1, 0, 480, 0);
    bus7.player_y = 16'd100;
    step7(1);
    chk7("s7.down_dec", 0, 53, 0, 1);
    for (int k = 1; k <= 7; k++) begin
      step7(1);
      chk7($sformatf("s7.dn%0d", k), 0, 53 - 7 * k, 0, 1);
    end
    step7(1);
    chk7("s7.down_end", 0, 0, 0, 0);
    step7(1);
    chk7("s7.idle", 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
